// File: rtl/mips_defs.sv
// Shared MIPS encodings for the P7 core: opcodes, functs, writeback source
// and load-type selectors used by the W-stage and hazard logic.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_COP0  = 6'b010000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;
    localparam logic [5:0] F_JALR = 6'b001001;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    localparam logic [4:0] COP0_MF = 5'b00000;
    localparam logic [4:0] RA      = 5'd31;

    typedef enum logic [2:0] {
        WB_NONE,
        WB_ALU,
        WB_LOAD,
        WB_PC8,
        WB_HILO,
        WB_CP0
    } wb_src_t;

    typedef enum logic [2:0] {
        LD_W,
        LD_H,
        LD_HU,
        LD_B,
        LD_BU
    } ld_type_t;

endpackage

// File: rtl/wb_decode.sv
// Combinational W-stage decode: destination register, writeback source and
// load type. Also usable by the hazard unit for W-stage destination lookup.
module wb_decode
    import mips_defs::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  dest,
    output wb_src_t     wb_src,
    output ld_type_t    ld_type
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs_f;
    logic [4:0] rt_f;
    logic [4:0] rd_f;
    logic       unused_shamt;

    assign op           = instr[31:26];
    assign rs_f         = instr[25:21];
    assign rt_f         = instr[20:16];
    assign rd_f         = instr[15:11];
    assign funct        = instr[5:0];
    assign unused_shamt = ^instr[10:6];

    // Anything not listed (stores, branches, j/jr, mult/div, mt*, eret,
    // syscall) leaves the defaults: no destination, no write.
    always_comb begin
        dest    = 5'd0;
        wb_src  = WB_NONE;
        ld_type = LD_W;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
                    F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV,
                    F_SRAV: begin
                        dest   = rd_f;
                        wb_src = WB_ALU;
                    end
                    F_JALR: begin
                        dest   = rd_f;
                        wb_src = WB_PC8;
                    end
                    F_MFHI, F_MFLO: begin
                        dest   = rd_f;
                        wb_src = WB_HILO;
                    end
                    default: ;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_SLTI,
            OP_SLTIU: begin
                dest   = rt_f;
                wb_src = WB_ALU;
            end
            OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
                dest   = rt_f;
                wb_src = WB_LOAD;
                case (op)
                    OP_LH:   ld_type = LD_H;
                    OP_LHU:  ld_type = LD_HU;
                    OP_LB:   ld_type = LD_B;
                    OP_LBU:  ld_type = LD_BU;
                    default: ld_type = LD_W;
                endcase
            end
            OP_COP0: begin
                if (rs_f == COP0_MF) begin
                    dest   = rt_f;
                    wb_src = WB_CP0;
                end
            end
            OP_JAL: begin
                dest   = RA;
                wb_src = WB_PC8;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/wb_grf.sv
// Writeback stage and general register file: selects/extracts the W-stage
// result, commits it, and serves two bypassed D-stage read ports plus a trace.
module wb_grf
    import mips_defs::*;
#(
    parameter int          NREG     = 32,
    parameter int          DW       = 32,
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   instr_W,
    input  logic [31:0]   PC_W,
    input  logic [DW-1:0] W_ALU_out,
    input  logic [DW-1:0] W_DM_out,
    input  logic [DW-1:0] W_HILO_out,
    input  logic [DW-1:0] W_CP0_out,
    input  logic [4:0]    rs_addr,
    input  logic [4:0]    rt_addr,
    output logic [DW-1:0] rs_data,
    output logic [DW-1:0] rt_data,
    output logic          wb_we,
    output logic [4:0]    wb_addr,
    output logic [DW-1:0] wb_data,
    output logic [31:0]   wb_pc
);

    logic [DW-1:0] regs [NREG];
    logic [4:0]    dest;
    wb_src_t       wb_src;
    ld_type_t      ld_type;
    logic [1:0]    byte_off;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [DW-1:0] ld_value;
    logic [DW-1:0] wb_value;

    wb_decode u_decode (
        .instr   (instr_W),
        .dest    (dest),
        .wb_src  (wb_src),
        .ld_type (ld_type)
    );

    assign byte_off = W_ALU_out[1:0];
    assign ld_byte  = W_DM_out[{byte_off, 3'b000} +: 8];
    assign ld_half  = byte_off[1] ? W_DM_out[31:16] : W_DM_out[15:0];

    // Halfword loads ignore address bit 0; misalignment traps happen earlier.
    always_comb begin
        ld_value = W_DM_out;
        case (ld_type)
            LD_B:    ld_value = {{(DW-8){ld_byte[7]}}, ld_byte};
            LD_BU:   ld_value = {{(DW-8){1'b0}}, ld_byte};
            LD_H:    ld_value = {{(DW-16){ld_half[15]}}, ld_half};
            LD_HU:   ld_value = {{(DW-16){1'b0}}, ld_half};
            default: ld_value = W_DM_out;
        endcase
    end

    always_comb begin
        wb_value = '0;
        case (wb_src)
            WB_ALU:  wb_value = W_ALU_out;
            WB_LOAD: wb_value = ld_value;
            WB_PC8:  wb_value = PC_W + 32'd8;
            WB_HILO: wb_value = W_HILO_out;
            WB_CP0:  wb_value = W_CP0_out;
            default: wb_value = '0;
        endcase
    end

    assign wb_we   = !reset && (wb_src != WB_NONE) && (dest != 5'd0);
    assign wb_addr = wb_we ? dest : 5'd0;
    assign wb_data = wb_we ? wb_value : '0;
    assign wb_pc   = reset ? PC_RESET : PC_W;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // The write committing at the coming edge is forwarded to same-cycle readers.
    assign rs_data = (reset || rs_addr == 5'd0) ? '0 :
                     (wb_we && wb_addr == rs_addr) ? wb_data : regs[rs_addr];
    assign rt_data = (reset || rt_addr == 5'd0) ? '0 :
                     (wb_we && wb_addr == rt_addr) ? wb_data : regs[rt_addr];

endmodule

// File: tb/tb_wb_grf.sv
// Scoreboard bench for wb_grf: each directed vector pushes its hand-computed
// expected outputs; a negedge monitor pops and compares them.
module tb_wb_grf;

    typedef struct packed {
        logic [7:0]  id;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
        logic [31:0] rs;
        logic [31:0] rt;
    } exp_t;

    localparam logic [31:0] I_ORI8   = 32'h3408_1234;
    localparam logic [31:0] I_LB9    = 32'h8009_0000;
    localparam logic [31:0] I_LBU10  = 32'h900A_0000;
    localparam logic [31:0] I_LH11   = 32'h840B_0000;
    localparam logic [31:0] I_LHU12  = 32'h940C_0000;
    localparam logic [31:0] I_LW13   = 32'h8C0D_0000;
    localparam logic [31:0] I_LB14   = 32'h800E_0000;
    localparam logic [31:0] I_JAL    = 32'h0C00_0000;
    localparam logic [31:0] I_JALR5  = 32'h00E0_2809;
    localparam logic [31:0] I_MFC0_4 = 32'h4004_7000;
    localparam logic [31:0] I_MFHI3  = 32'h0000_1810;
    localparam logic [31:0] I_MFLO6  = 32'h0000_3012;
    localparam logic [31:0] I_ADDU0  = 32'h0022_0021;
    localparam logic [31:0] I_SW8    = 32'hAC08_0000;
    localparam logic [31:0] I_MTC0   = 32'h4088_7000;
    localparam logic [31:0] I_ADDI2  = 32'h2002_0000;
    localparam logic [31:0] DMW      = 32'h80FF_00AA;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_W, PC_W, W_ALU_out, W_DM_out, W_HILO_out, W_CP0_out;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data, wb_data, wb_pc;
    logic        wb_we;
    logic [4:0]  wb_addr;

    exp_t        sb[$];
    exp_t        cur;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  vec_id = 8'd0;

    wb_grf dut (
        .clk        (clk),
        .reset      (reset),
        .instr_W    (instr_W),
        .PC_W       (PC_W),
        .W_ALU_out  (W_ALU_out),
        .W_DM_out   (W_DM_out),
        .W_HILO_out (W_HILO_out),
        .W_CP0_out  (W_CP0_out),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wb_pc      (wb_pc)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] id,
                               input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s vec%0d actual=%h required=%h", name, id, act, req);
        end
    endtask

    task automatic applyStimulus(
        input logic rst, input logic [31:0] instr, input logic [31:0] pc,
        input logic [31:0] alu, input logic [31:0] dm, input logic [31:0] hilo,
        input logic [31:0] cp0, input logic [4:0] ra, input logic [4:0] rb,
        input logic ewe, input logic [4:0] eaddr, input logic [31:0] edata,
        input logic [31:0] epc, input logic [31:0] ers, input logic [31:0] ert);
        exp_t e;
        @(posedge clk);
        #1;
        reset      = rst;
        instr_W    = instr;
        PC_W       = pc;
        W_ALU_out  = alu;
        W_DM_out   = dm;
        W_HILO_out = hilo;
        W_CP0_out  = cp0;
        rs_addr    = ra;
        rt_addr    = rb;
        e.id   = vec_id;
        e.we   = ewe;
        e.addr = eaddr;
        e.data = edata;
        e.pc   = epc;
        e.rs   = ers;
        e.rt   = ert;
        sb.push_back(e);
        vec_id = vec_id + 8'd1;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            checkOutput("wb_we",   cur.id, {31'd0, wb_we},  {31'd0, cur.we});
            checkOutput("wb_addr", cur.id, {27'd0, wb_addr}, {27'd0, cur.addr});
            checkOutput("wb_data", cur.id, wb_data, cur.data);
            checkOutput("wb_pc",   cur.id, wb_pc,   cur.pc);
            checkOutput("rs_data", cur.id, rs_data, cur.rs);
            checkOutput("rt_data", cur.id, rt_data, cur.rt);
        end
    end

    initial begin
        reset = 1'b1; instr_W = '0; PC_W = '0; W_ALU_out = '0; W_DM_out = '0;
        W_HILO_out = '0; W_CP0_out = '0; rs_addr = '0; rt_addr = '0;

        // Reset held: every address reads 0, trace idle, writes ignored.
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, (i % 2 == 1) ? I_ORI8 : 32'h0, 32'h0, 32'h1234, DMW, 0, 0,
                          i[4:0], 5'(31 - i), 0, 5'd0, 32'h0, 32'h3000, 32'h0, 32'h0);
        end

        applyStimulus(0, I_ORI8,   32'h3000, 32'h1234, DMW, 0, 0, 5'd8, 5'd0,
                      1, 5'd8, 32'h1234, 32'h3000, 32'h1234, 32'h0);
        applyStimulus(0, 32'h0,    32'h4180, 32'h0, DMW, 0, 0, 5'd8, 5'd8,
                      0, 5'd0, 32'h0, 32'h4180, 32'h1234, 32'h1234);
        applyStimulus(0, I_LB9,    32'h3004, 32'h3, DMW, 0, 0, 5'd9, 5'd8,
                      1, 5'd9, 32'hFFFF_FF80, 32'h3004, 32'hFFFF_FF80, 32'h1234);
        applyStimulus(0, I_LBU10,  32'h3008, 32'h3, DMW, 0, 0, 5'd9, 5'd10,
                      1, 5'd10, 32'h80, 32'h3008, 32'hFFFF_FF80, 32'h80);
        applyStimulus(0, I_LH11,   32'h300C, 32'h2, DMW, 0, 0, 5'd11, 5'd11,
                      1, 5'd11, 32'hFFFF_80FF, 32'h300C, 32'hFFFF_80FF, 32'hFFFF_80FF);
        applyStimulus(0, I_LHU12,  32'h3010, 32'h0, DMW, 0, 0, 5'd12, 5'd10,
                      1, 5'd12, 32'hAA, 32'h3010, 32'hAA, 32'h80);
        applyStimulus(0, I_LW13,   32'h3014, 32'h1, DMW, 0, 0, 5'd13, 5'd11,
                      1, 5'd13, DMW, 32'h3014, DMW, 32'hFFFF_80FF);
        applyStimulus(0, I_LB14,   32'h3018, 32'h2, DMW, 0, 0, 5'd14, 5'd12,
                      1, 5'd14, 32'hFFFF_FFFF, 32'h3018, 32'hFFFF_FFFF, 32'hAA);
        applyStimulus(0, I_JAL,    32'h3010, 32'h0, DMW, 0, 0, 5'd31, 5'd8,
                      1, 5'd31, 32'h3018, 32'h3010, 32'h3018, 32'h1234);
        applyStimulus(0, I_JALR5,  32'h3010, 32'h0, DMW, 0, 0, 5'd5, 5'd31,
                      1, 5'd5, 32'h3018, 32'h3010, 32'h3018, 32'h3018);
        applyStimulus(0, I_MFC0_4, 32'h3014, 32'h0, DMW, 0, 32'h4180, 5'd4, 5'd5,
                      1, 5'd4, 32'h4180, 32'h3014, 32'h4180, 32'h3018);
        applyStimulus(0, I_MFHI3,  32'h3018, 32'h0, DMW, 32'hDEAD_BEEF, 0, 5'd3, 5'd4,
                      1, 5'd3, 32'hDEAD_BEEF, 32'h3018, 32'hDEAD_BEEF, 32'h4180);
        applyStimulus(0, I_MFLO6,  32'h301C, 32'h0, DMW, 32'h0BAD_F00D, 0, 5'd6, 5'd3,
                      1, 5'd6, 32'h0BAD_F00D, 32'h301C, 32'h0BAD_F00D, 32'hDEAD_BEEF);
        applyStimulus(0, I_ADDU0,  32'h3020, 32'h55, DMW, 0, 0, 5'd0, 5'd0,
                      0, 5'd0, 32'h0, 32'h3020, 32'h0, 32'h0);
        applyStimulus(0, I_SW8,    32'h3024, 32'h100, DMW, 0, 0, 5'd8, 5'd0,
                      0, 5'd0, 32'h0, 32'h3024, 32'h1234, 32'h0);
        applyStimulus(0, I_MTC0,   32'h3028, 32'h77, DMW, 0, 32'h55, 5'd4, 5'd6,
                      0, 5'd0, 32'h0, 32'h3028, 32'h4180, 32'h0BAD_F00D);
        applyStimulus(0, 32'h0,    32'h4180, 32'h0, DMW, 0, 0, 5'd0, 5'd9,
                      0, 5'd0, 32'h0, 32'h4180, 32'h0, 32'hFFFF_FF80);
        // Reset with a coincident write; the write must be lost.
        applyStimulus(1, I_ORI8,   32'h302C, 32'h9999, DMW, 0, 0, 5'd8, 5'd31,
                      0, 5'd0, 32'h0, 32'h3000, 32'h0, 32'h0);
        applyStimulus(0, 32'h0,    32'h4180, 32'h0, DMW, 0, 0, 5'd8, 5'd13,
                      0, 5'd0, 32'h0, 32'h4180, 32'h0, 32'h0);
        applyStimulus(0, 32'h0,    32'h4180, 32'h0, DMW, 0, 0, 5'd31, 5'd3,
                      0, 5'd0, 32'h0, 32'h4180, 32'h0, 32'h0);
        applyStimulus(0, I_ADDI2,  32'h3030, 32'h77, DMW, 0, 0, 5'd2, 5'd8,
                      1, 5'd2, 32'h77, 32'h3030, 32'h77, 32'h0);

        for (int k = 0; k < 10 && sb.size() != 0; k++) begin
            @(posedge clk);
        end
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain pending=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
